// File: rtl/rr_mux_arbiter.sv
// ---------------------------------------------------------------------------
// rr_mux_arbiter
//   Round-robin arbiter that shares one bit-serial output line between four
//   requesters. The current owner's index selects an internal 4:1 mux, so
//   only the granted requester's data bit reaches y. A hold limit bounds how
//   long one owner keeps the line while somebody else is waiting.
//
//   Ports
//     clock    in   1  system clock, rising edge
//     reset_b  in   1  asynchronous active-low reset
//     req      in   4  per-requester request, held while access is wanted
//     x        in   4  per-requester data bit, x[i] belongs to req[i]
//     gnt      out  4  registered one-hot grant, 0 when idle
//     sel      out  2  index of current owner, drives the mux select
//     valid    out  1  |gnt
//     y        out  1  x[sel] while valid, else 0
//
//   state | meaning
//   IDLE  | no grant held, waiting for any request
//   GRANT | one requester owns the line (index in sel_q)
// ---------------------------------------------------------------------------

module mux_4x1 (
    input  logic [3:0] d,
    input  logic [1:0] s,
    output logic       o
);
    assign o = d[s];
endmodule

module rr_mux_arbiter #(
    parameter int MAX_HOLD = 8,
    parameter int CNT_W    = 3
) (
    input  logic       clock,
    input  logic       reset_b,
    input  logic [3:0] req,
    input  logic [3:0] x,
    output logic [3:0] gnt,
    output logic [1:0] sel,
    output logic       valid,
    output logic       y
);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);

    state_t           state_q, state_d;
    logic [3:0]       gnt_q, gnt_d;
    logic [1:0]       sel_q, sel_d;
    logic [1:0]       last_q, last_d;
    logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;

    logic             win_found;
    logic [1:0]       win_idx;
    logic             others_pending;
    logic             mux_out;

    // Search starts one past the last owner. In GRANT last_q equals the
    // owner, so the owner itself is the final candidate and can only win
    // when nobody else is requesting.
    always_comb begin
        logic [1:0] idx;
        win_found = 1'b0;
        win_idx   = last_q;
        idx       = last_q;
        for (int k = 1; k <= 4; k++) begin
            idx = last_q + 2'(k);
            if (!win_found && req[idx]) begin
                win_found = 1'b1;
                win_idx   = idx;
            end
        end
    end

    assign others_pending = |(req & ~gnt_q);

    always_comb begin
        state_d    = state_q;
        gnt_d      = gnt_q;
        sel_d      = sel_q;
        last_d     = last_q;
        hold_cnt_d = hold_cnt_q;

        case (state_q)
            IDLE: begin
                if (win_found) begin
                    state_d    = GRANT;
                    gnt_d      = 4'b0001 << win_idx;
                    sel_d      = win_idx;
                    last_d     = win_idx;
                    hold_cnt_d = '0;
                end
            end

            GRANT: begin
                if (!req[sel_q]) begin
                    if (others_pending) begin
                        // direct handover, no idle gap
                        gnt_d      = 4'b0001 << win_idx;
                        sel_d      = win_idx;
                        last_d     = win_idx;
                        hold_cnt_d = '0;
                    end else begin
                        state_d    = IDLE;
                        gnt_d      = 4'b0000;
                        hold_cnt_d = '0;
                    end
                end else if (hold_cnt_q == HOLD_LAST && others_pending) begin
                    // tenure exhausted with someone waiting: preempt
                    gnt_d      = 4'b0001 << win_idx;
                    sel_d      = win_idx;
                    last_d     = win_idx;
                    hold_cnt_d = '0;
                end else if (hold_cnt_q != HOLD_LAST) begin
                    // saturating, so a lone requester is never preempted
                    hold_cnt_d = hold_cnt_q + CNT_W'(1);
                end
            end

            default: begin
                state_d    = IDLE;
                gnt_d      = 4'b0000;
                hold_cnt_d = '0;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset_b) begin
        if (!reset_b) begin
            state_q    <= IDLE;
            gnt_q      <= 4'b0000;
            sel_q      <= 2'b00;
            last_q     <= 2'd3;
            hold_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            gnt_q      <= gnt_d;
            sel_q      <= sel_d;
            last_q     <= last_d;
            hold_cnt_q <= hold_cnt_d;
        end
    end

    mux_4x1 u_mux (
        .d (x),
        .s (sel_q),
        .o (mux_out)
    );

    assign gnt   = gnt_q;
    assign sel   = sel_q;
    assign valid = |gnt_q;
    assign y     = valid & mux_out;

endmodule

// File: tb/tb_rr_mux_arbiter.sv
module tb_rr_mux_arbiter;

    logic       clock;
    logic       reset_b;
    logic [3:0] req;
    logic [3:0] x;
    logic [3:0] gnt;
    logic [1:0] sel;
    logic       valid;
    logic       y;

    int n_cmp = 0;
    int n_err = 0;

    rr_mux_arbiter #(.MAX_HOLD(8), .CNT_W(3)) dut (
        .clock   (clock),
        .reset_b (reset_b),
        .req     (req),
        .x       (x),
        .gnt     (gnt),
        .sel     (sel),
        .valid   (valid),
        .y       (y)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [3:0] eg, input logic [1:0] es);
        chk({tag, "_gnt"}, 32'(gnt), 32'(eg));
        chk({tag, "_sel"}, 32'(sel), 32'(es));
        chk({tag, "_valid"}, 32'(valid), 32'(|eg));
        chk({tag, "_y"}, 32'(y), 32'((|eg) & x[es]));
    endtask

    initial begin
        int         seq [5];
        logic [3:0] p_gnt;
        logic [3:0] p_req;
        logic       p_others;
        int         p_ten;
        int         ten;
        int         wt [4];

        reset_b = 1'b0;
        req     = 4'b0000;
        x       = 4'b0000;
        #3;
        chk_all("reset", 4'b0000, 2'b00);
        tick(2);
        reset_b = 1'b1;

        // single requester 2, y follows x[2] combinationally
        req = 4'b0100; x = 4'b0100;
        tick(1);
        chk_all("t2_grant", 4'b0100, 2'b10);
        chk("t2_y_hi", 32'(y), 32'd1);
        x = 4'b0000; #1;
        chk("t2_y_lo", 32'(y), 32'd0);
        req = 4'b0000; x = 4'b1111;
        tick(1);
        chk_all("t2_idle", 4'b0000, 2'b10);

        // async reset mid-grant
        req = 4'b1111;
        tick(1);
        chk_all("t1_pre", 4'b1000, 2'b11);
        tick(2);
        reset_b = 1'b0; #1;
        chk("t1_rst_gnt", 32'(gnt), 32'd0);
        chk("t1_rst_valid", 32'(valid), 32'd0);
        chk("t1_rst_y", 32'(y), 32'd0);
        tick(1);
        reset_b = 1'b1;
        tick(1);

        // full load: 0,1,2,3,0 each 8 cycles, back to back
        seq = '{0, 1, 2, 3, 0};
        for (int o = 0; o < 5; o++) begin
            for (int c = 0; c < 8; c++) begin
                x = 4'($urandom);
                #1;
                chk_all("t3_rot", 4'b0001 << seq[o], 2'(seq[o]));
                tick(1);
            end
        end
        chk_all("t3_next", 4'b0010, 2'b01);
        req = 4'b0000;
        tick(1);
        chk_all("t3_idle", 4'b0000, 2'b01);

        // owner drops early, pending requester takes over with fresh tenure
        req = 4'b0001;
        tick(1);
        chk_all("t4_own0", 4'b0001, 2'b00);
        req = 4'b0011;
        tick(2);
        chk_all("t4_c3", 4'b0001, 2'b00);
        req = 4'b0010;
        tick(1);
        chk_all("t4_hand", 4'b0010, 2'b01);
        req = 4'b0011;
        for (int c = 0; c < 8; c++) begin
            chk_all("t4_hold", 4'b0010, 2'b01);
            tick(1);
        end
        chk_all("t4_pre", 4'b0001, 2'b00);

        // sole requester never preempted
        req = 4'b1000;
        tick(1);
        for (int c = 0; c < 20; c++) begin
            chk_all("t5_solo", 4'b1000, 2'b11);
            tick(1);
        end
        req = 4'b0000;
        tick(1);
        chk("t5_drop_gnt", 32'(gnt), 32'd0);
        chk("t5_drop_valid", 32'(valid), 32'd0);

        // random traffic with invariant checks
        ten = 0;
        for (int i = 0; i < 4; i++) wt[i] = 0;
        for (int n = 0; n < 2000; n++) begin
            if ($urandom_range(7) == 0) req = 4'($urandom);
            x = 4'($urandom);
            #1;
            chk("r_y", 32'(y), 32'(valid & x[sel]));
            p_gnt    = gnt;
            p_req    = req;
            p_others = |(req & ~gnt);
            p_ten    = ten;
            tick(1);
            chk("r_onehot", 32'($onehot0(gnt)), 32'd1);
            chk("r_valid", 32'(valid), 32'(|gnt));
            chk("r_sel", 32'((!valid) || (gnt == (4'b0001 << sel))), 32'd1);
            chk("r_tenure", 32'(!(p_gnt != 4'b0000 && p_ten >= 8 && p_others && gnt == p_gnt)), 32'd1);
            if (gnt != 4'b0000 && gnt == p_gnt) ten = ten + 1;
            else ten = (gnt != 4'b0000) ? 1 : 0;
            for (int i = 0; i < 4; i++) begin
                if (p_req[i] && !gnt[i]) wt[i] = wt[i] + 1;
                else wt[i] = 0;
                chk("r_starve", 32'(wt[i] <= 25), 32'd1);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
